// File: rtl/write_back_register_file_if.sv
// write_back_register_file_if: write-back and register read bus between pipeline and register file.
interface write_back_register_file_if #(parameter int DATA_WIDTH = 32);
  logic                  writeBackFromMemoryOrAlu;
  logic [DATA_WIDTH-1:0] memoryReadData;
  logic [DATA_WIDTH-1:0] aluData;
  logic                  registerWriteEnable;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [DATA_WIDTH-1:0] rs1Data;
  logic [DATA_WIDTH-1:0] rs2Data;
  logic [DATA_WIDTH-1:0] writeBackData;
  logic [DATA_WIDTH-1:0] retiredWriteCount;
  modport master (
    output writeBackFromMemoryOrAlu, memoryReadData, aluData, registerWriteEnable, rd, rs1, rs2,
    input  rs1Data, rs2Data, writeBackData, retiredWriteCount
  );
  modport slave (
    input  writeBackFromMemoryOrAlu, memoryReadData, aluData, registerWriteEnable, rd, rs1, rs2,
    output rs1Data, rs2Data, writeBackData, retiredWriteCount
  );
endinterface

// File: rtl/write_back_register_file.sv
// write_back_register_file: 2-read/1-write register file with write-back mux, same-cycle bypass and retired-write counter.
module write_back_register_file #(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTER_COUNT = 32
) (
  input logic                        clock,
  input logic                        reset,
  write_back_register_file_if.slave  bus
);
  logic [DATA_WIDTH-1:0] regs_q [REGISTER_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REGISTER_COUNT];
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] wb;
  logic                  commit;
  always_comb begin
    wb      = bus.writeBackFromMemoryOrAlu ? bus.memoryReadData : bus.aluData;
    // reset gates commit, which also suppresses bypass while reset is low
    commit  = reset && bus.registerWriteEnable && (bus.rd != 5'd0);
    regs_d  = regs_q;
    if (commit) regs_d[bus.rd] = wb;
    count_d = count_q + DATA_WIDTH'(commit);
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      regs_q  <= '{default: '0};
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end
  assign bus.writeBackData     = wb;
  assign bus.retiredWriteCount = count_q;
  assign bus.rs1Data = (bus.rs1 == 5'd0) ? '0 : (commit && bus.rd == bus.rs1) ? wb : regs_q[bus.rs1];
  assign bus.rs2Data = (bus.rs2 == 5'd0) ? '0 : (commit && bus.rd == bus.rs2) ? wb : regs_q[bus.rs2];
endmodule
